lsu_ctrl: RTL and testbench

Load/store initiator between the pipeline MEM stage and a word-only data memory port with variable-latency request/acknowledge. It accepts one word, halfword or byte access at a time and checks alignment. Sub-word stores become read-modify-write sequences. Loads return zero- or sign-extended data, and an unacknowledged memory access is terminated by a timeout.

---
 rtl/lsu_ctrl_pkg.sv | 31 +++
 rtl/lsu_lane.sv | 47 ++++
 rtl/lsu_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared data-memory constants for the load/store controller.
// Holds the DM_* access-mode encodings, the LSU_FAULT_* response codes,
// the FSM state encodings and a helper that checks a mode for legality.
package lsu_ctrl_pkg;

    // Access modes
    localparam logic [2:0] DM_NONE = 3'd0;
    localparam logic [2:0] DM_W    = 3'd1;
    localparam logic [2:0] DM_H    = 3'd2;
    localparam logic [2:0] DM_HU   = 3'd3;
    localparam logic [2:0] DM_B    = 3'd4;
    localparam logic [2:0] DM_BU   = 3'd5;

    // Response fault codes
    localparam logic [1:0] LSU_FAULT_OK       = 2'b00;
    localparam logic [1:0] LSU_FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] LSU_FAULT_TIMEOUT  = 2'b11;

    // FSM states
    localparam logic [1:0] LSU_ST_IDLE = 2'd0;
    localparam logic [1:0] LSU_ST_RD   = 2'd1;
    localparam logic [1:0] LSU_ST_WR   = 2'd2;
    localparam logic [1:0] LSU_ST_RESP = 2'd3;

    // Encodings 6 and 7 are unassigned.
    function automatic logic dm_mode_legal(input logic [2:0] mode);
        return mode <= DM_BU;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte lane logic for the load/store controller.
//   word_i   : word read from memory (old word for merges, source for loads)
//   wdata_i  : right-aligned store data (halfword in [15:0], byte in [7:0])
//   off_i    : byte offset addr[1:0]
//   mode_i   : DM_* access mode
//   merged_o : word_i with the store data inserted at the addressed lane
//   load_o   : addressed word/halfword/byte, sign- or zero-extended
module lsu_lane
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  mode_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        byte_sel = word_i[{off_i, 3'b000} +: 8];

        merged_o = word_i;
        if (mode_i == DM_H) begin
            if (off_i[1]) begin
                merged_o[31:16] = wdata_i;
            end else begin
                merged_o[15:0] = wdata_i;
            end
        end else if (mode_i == DM_B) begin
            merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        end

        case (mode_i)
            DM_W:    load_o = word_i;
            DM_H:    load_o = {{16{half_sel[15]}}, half_sel};
            DM_HU:   load_o = {16'h0000, half_sel};
            DM_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   load_o = {24'h000000, byte_sel};
            default: load_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the MEM stage and a word-only memory port.
// Accepts one access at a time, checks mode/alignment, turns sub-word stores
// into read-modify-write and terminates unacknowledged phases by timeout.
//   clk, reset_n          : clock, synchronous active-low reset
//   req_*                 : request from the pipeline (valid/ready handshake)
//   resp_*                : one-cycle completion pulse with data, fault, pc
//   mem_req/we/addr/wdata : registered word request, held until mem_ack
//   mem_ack, mem_rdata    : memory completion and read data
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic [31:0] resp_pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  mode_q, mode_d;
    logic [1:0]  off_q, off_d;
    // Only the low halfword feeds the merge; full-word stores go straight out.
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;

    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]  resp_fault_q, resp_fault_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] lane_merged;
    logic [31:0] lane_load;

    lsu_lane u_lane (
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q),
        .off_i    (off_q),
        .mode_i   (mode_q),
        .merged_o (lane_merged),
        .load_o   (lane_load)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        mode_d       = mode_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        resp_pc_d    = resp_pc_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            LSU_ST_IDLE: begin
                if (req_valid) begin
                    write_d      = req_write;
                    mode_d       = req_mode;
                    off_d        = req_addr[1:0];
                    wdata_d      = req_wdata[15:0];
                    resp_pc_d    = req_pc;
                    resp_rdata_d = 32'h0000_0000;
                    resp_fault_d = LSU_FAULT_OK;
                    // Checks are prioritised: legality, then alignment.
                    if (!dm_mode_legal(req_mode) ||
                        (req_write && (req_mode == DM_HU || req_mode == DM_BU))) begin
                        resp_fault_d = LSU_FAULT_ILLEGAL;
                        resp_valid_d = 1'b1;
                        state_d      = LSU_ST_RESP;
                    end else if (req_mode == DM_W && req_addr[1:0] != 2'b00) begin
                        resp_fault_d = LSU_FAULT_MISALIGN;
                        resp_valid_d = 1'b1;
                        state_d      = LSU_ST_RESP;
                    end else if ((req_mode == DM_H || req_mode == DM_HU) && req_addr[0]) begin
                        resp_fault_d = LSU_FAULT_MISALIGN;
                        resp_valid_d = 1'b1;
                        state_d      = LSU_ST_RESP;
                    end else if (req_mode == DM_NONE) begin
                        resp_valid_d = 1'b1;
                        state_d      = LSU_ST_RESP;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        cnt_d      = 16'h0000;
                        if (req_write && req_mode == DM_W) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                            state_d     = LSU_ST_WR;
                        end else begin
                            mem_we_d = 1'b0;
                            state_d  = LSU_ST_RD;
                        end
                    end
                end
            end

            LSU_ST_RD: begin
                if (mem_ack) begin
                    cnt_d = 16'h0000;
                    if (write_q) begin
                        // Sub-word store: keep the request up and turn it into the write.
                        mem_we_d    = 1'b1;
                        mem_wdata_d = lane_merged;
                        state_d     = LSU_ST_WR;
                    end else begin
                        mem_req_d    = 1'b0;
                        resp_rdata_d = lane_load;
                        resp_valid_d = 1'b1;
                        state_d      = LSU_ST_RESP;
                    end
                end else if (cnt_q == TimeoutCnt) begin
                    mem_req_d    = 1'b0;
                    resp_fault_d = LSU_FAULT_TIMEOUT;
                    resp_valid_d = 1'b1;
                    state_d      = LSU_ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            LSU_ST_WR: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = LSU_ST_RESP;
                end else if (cnt_q == TimeoutCnt) begin
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_fault_d = LSU_FAULT_TIMEOUT;
                    resp_valid_d = 1'b1;
                    state_d      = LSU_ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            LSU_ST_RESP: begin
                state_d = LSU_ST_IDLE;
            end

            default: begin
                state_d = LSU_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= LSU_ST_IDLE;
            write_q      <= 1'b0;
            mode_q       <= DM_NONE;
            off_q        <= 2'b00;
            wdata_q      <= 16'h0000;
            cnt_q        <= 16'h0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_fault_q <= LSU_FAULT_OK;
            resp_pc_q    <= 32'h0000_0000;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            mode_q       <= mode_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            resp_pc_q    <= resp_pc_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Gated with reset_n so the block never looks ready while held in reset.
    assign req_ready  = reset_n && (state_q == LSU_ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign resp_pc    = resp_pc_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: requests push their expected response,
// a monitor pops and compares on every resp_valid, and a memory model
// with programmable wait states logs every write.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic [31:0] resp_pc;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    lsu_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_mode   (req_mode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .resp_pc    (resp_pc),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [1:0]  fault;
        logic [31:0] pc;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model: ack after wait_cfg wait cycles; writes can be withheld.
    logic [31:0] mem [logic [31:0]];
    bit          ack_en     = 1'b1;
    bit          ack_wr     = 1'b1;
    int          wait_cfg   = 0;
    int          wcnt       = 0;
    int          req_cycles = 0;
    logic [63:0] wr_log[$];

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            if (mem_req === 1'b1) req_cycles++;
            if (mem_req === 1'b1 && ack_en && (ack_wr || !mem_we)) begin
                if (wcnt == wait_cfg) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wr_log.push_back({mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every response must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid=1 (pc %h), expected none",
                             resp_pc);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                    chk({e.name, "_fault"}, 32'(resp_fault), 32'(e.fault));
                    chk({e.name, "_pc"}, resp_pc, e.pc);
                    chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic issue(input string name, input bit wr, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata_exp, input logic [1:0] fault_exp,
                         input int lat, input bit expect_resp);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: got req_ready=%b, expected 1 within 50 cycles",
                     name, req_ready);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = pc_ctr;
        if (expect_resp) begin
            e.name  = name;
            e.rdata = rdata_exp;
            e.fault = fault_exp;
            e.pc    = pc_ctr;
            e.acc   = cyc;
            e.lat   = lat;
            sb_q.push_back(e);
        end
        pc_ctr = pc_ctr + 32'd4;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int waited = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || req_ready !== 1'b1) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0 || req_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain: got %0d pending responses, expected 0", name, sb_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish within time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_mode  = DM_NONE;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_pc    = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready_low", 32'(req_ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_high", 32'(req_ready), 32'd1);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);

        // Load extension on 0x80FF7F01, zero-wait memory.
        mem[32'h100] = 32'h80FF_7F01;
        req_cycles   = 0;
        issue("lb_100",  1'b0, DM_B,  32'h100, 32'h0, 32'h0000_0001, LSU_FAULT_OK, 2, 1'b1);
        issue("lb_102",  1'b0, DM_B,  32'h102, 32'h0, 32'hFFFF_FFFF, LSU_FAULT_OK, 2, 1'b1);
        issue("lbu_103", 1'b0, DM_BU, 32'h103, 32'h0, 32'h0000_0080, LSU_FAULT_OK, 2, 1'b1);
        issue("lh_102",  1'b0, DM_H,  32'h102, 32'h0, 32'hFFFF_80FF, LSU_FAULT_OK, 2, 1'b1);
        issue("lhu_100", 1'b0, DM_HU, 32'h100, 32'h0, 32'h0000_7F01, LSU_FAULT_OK, 2, 1'b1);
        issue("lw_100",  1'b0, DM_W,  32'h100, 32'h0, 32'h80FF_7F01, LSU_FAULT_OK, 2, 1'b1);
        wait_idle("loads");
        chk("loads_req_cycles", 32'(req_cycles), 32'd6);
        chk("loads_no_write", 32'(wr_log.size()), 32'd0);

        // Sub-word stores become read-modify-write.
        mem[32'h100] = 32'h1122_3344;
        req_cycles   = 0;
        issue("sh_102", 1'b1, DM_H, 32'h102, 32'h0000_ABCD, 32'h0, LSU_FAULT_OK, 3, 1'b1);
        wait_idle("sh");
        chk("sh_req_cycles", 32'(req_cycles), 32'd2);
        chk("sh_write_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() > 0) begin
            chk("sh_write_addr", wr_log[0][63:32], 32'h0000_0100);
            chk("sh_write_data", wr_log[0][31:0], 32'hABCD_3344);
        end
        wr_log.delete();
        issue("sb_101", 1'b1, DM_B, 32'h101, 32'h1234_56EE, 32'h0, LSU_FAULT_OK, 3, 1'b1);
        issue("lw_rmw", 1'b0, DM_W, 32'h100, 32'h0, 32'hABCD_EE44, LSU_FAULT_OK, 2, 1'b1);
        wait_idle("sb");
        chk("sb_write_count", 32'(wr_log.size()), 32'd1);
        wr_log.delete();

        // Faults and DM_NONE never touch memory.
        req_cycles = 0;
        issue("lw_102",   1'b0, DM_W,   32'h102, 32'h0, 32'h0, LSU_FAULT_MISALIGN, 1, 1'b1);
        issue("sbu_100",  1'b1, DM_BU,  32'h100, 32'h0, 32'h0, LSU_FAULT_ILLEGAL,  1, 1'b1);
        issue("shu_100",  1'b1, DM_HU,  32'h100, 32'h0, 32'h0, LSU_FAULT_ILLEGAL,  1, 1'b1);
        issue("mode7",    1'b0, 3'd7,   32'h101, 32'h0, 32'h0, LSU_FAULT_ILLEGAL,  1, 1'b1);
        issue("lh_101",   1'b0, DM_H,   32'h101, 32'h0, 32'h0, LSU_FAULT_MISALIGN, 1, 1'b1);
        issue("sw_201",   1'b1, DM_W,   32'h201, 32'h0, 32'h0, LSU_FAULT_MISALIGN, 1, 1'b1);
        issue("none_100", 1'b0, DM_NONE, 32'h100, 32'h0, 32'h0, LSU_FAULT_OK,      1, 1'b1);
        wait_idle("faults");
        chk("faults_req_cycles", 32'(req_cycles), 32'd0);

        // Word store with three wait cycles.
        wait_cfg   = 3;
        req_cycles = 0;
        issue("sw_200", 1'b1, DM_W, 32'h200, 32'hDEAD_BEEF, 32'h0, LSU_FAULT_OK, 5, 1'b1);
        wait_idle("sw");
        wait_cfg = 0;
        chk("sw_req_cycles", 32'(req_cycles), 32'd4);
        chk("sw_write_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() > 0) begin
            chk("sw_write_addr", wr_log[0][63:32], 32'h0000_0200);
            chk("sw_write_data", wr_log[0][31:0], 32'hDEAD_BEEF);
        end
        wr_log.delete();

        // Timeouts: read phase, then the write phase of an RMW.
        ack_en     = 1'b0;
        req_cycles = 0;
        issue("lw_to", 1'b0, DM_W, 32'h0, 32'h0, 32'h0, LSU_FAULT_TIMEOUT, 6, 1'b1);
        wait_idle("lw_to");
        chk("lw_to_req_cycles", 32'(req_cycles), 32'd5);
        chk("lw_to_ready", 32'(req_ready), 32'd1);
        ack_en     = 1'b1;
        ack_wr     = 1'b0;
        req_cycles = 0;
        issue("sb_to", 1'b1, DM_B, 32'h100, 32'h0000_0077, 32'h0, LSU_FAULT_TIMEOUT, 7, 1'b1);
        wait_idle("sb_to");
        chk("sb_to_req_cycles", 32'(req_cycles), 32'd6);
        chk("sb_to_no_write", 32'(wr_log.size()), 32'd0);

        // Reset while the write phase of an sb is pending.
        mem[32'h300] = 32'h0102_0304;
        issue("sb_rst", 1'b1, DM_B, 32'h300, 32'h0000_0099, 32'h0, LSU_FAULT_OK, 3, 1'b0);
        waited = 0;
        @(negedge clk);
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_mid_in_wr", 32'(mem_req & mem_we), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_ready_low", 32'(req_ready), 32'd0);
        reset_n = 1'b1;
        ack_wr  = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready_high", 32'(req_ready), 32'd1);
        issue("lw_after_rst", 1'b0, DM_W, 32'h300, 32'h0, 32'h0102_0304, LSU_FAULT_OK, 2, 1'b1);
        wait_idle("after_rst");
        chk("rst_mid_no_write", 32'(wr_log.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
